regfile_wb_arbiter: RTL and testbench

Shares the register file's single write port between two writeback requesters: the ALU result path (requester 0) and the load path (requester 1). Each requester pushes (address, data) into its own small FIFO through a valid/ready handshake. Each cycle, an arbiter drains at most one entry into a registered write stage that drives the register file's write-enable, write-address and write-data inputs. An 8-bit pending mask tells decode which architectural registers still have writes in flight, so decode can stall on read-after-write hazards.

---
 rtl/regfile_pkg.sv | 26 ++
 rtl/wb_fifo.sv | 74 +++++++
 rtl/regfile_wb_arbiter.sv | 129 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the register-file writeback path.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
//
// Contents: register geometry constants, the wb_req_t writeback request
// struct {addr, data}, and the one-hot register decode used to build the
// pending mask.
package regfile_pkg;

  localparam int REG_DATA_W = 8;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 8;
  // Only the low address bits select an architectural register.
  localparam int REG_SEL_W  = $clog2(NUM_REGS);

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_req_t;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_SEL_W-1:0] sel);
    reg_onehot      = '0;
    reg_onehot[sel] = 1'b1;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of writeback requests, one per requester.
// Latency: an entry pushed at edge E is visible at the head after E.
// Backpressure: pushes while full and pops while empty are ignored.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset (empties the FIFO)
//   push, push_req  write one wb_req_t
//   pop             drop the head entry
//   head            current oldest entry (meaningless when count==0)
//   count           number of valid entries, 0..DEPTH
//   ent_vld/ent_sel per-slot valid bit and register select, for pending
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               push,
  input  wb_req_t                            push_req,
  input  logic                               pop,
  output wb_req_t                            head,
  output logic [CNT_W-1:0]                   count,
  output logic [DEPTH-1:0]                   ent_vld,
  output logic [DEPTH-1:0][REG_SEL_W-1:0]    ent_sel
);

  wb_req_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] ofs [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push & (count != CNT_W'(DEPTH));
  assign pop_ok  = pop & (count != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; ent_vld masks stale slots.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_req;
  end

  assign head = mem[rd_ptr];

  // A slot holds a live entry when its distance from the read pointer is
  // below the fill count. DEPTH is a power of two, so the pointer
  // subtraction wraps correctly.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ofs[i]     = PTR_W'(i) - rd_ptr;
      ent_vld[i] = ({1'b0, ofs[i]} < count);
      ent_sel[i] = mem[i].addr[REG_SEL_W-1:0];
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port between the ALU (0) and load (1) writeback paths.
// Latency: accepted at edge E, earliest issue at E+1, register file captures at E+2.
// Backpressure: sN_ready drops while FIFO N holds DEPTH entries; independent of same-cycle pops.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   s0_valid/addr/data/ready      ALU writeback request, valid/ready handshake
//   s1_valid/addr/data/ready      load writeback request, valid/ready handshake
//   rf_we, rf_addr, rf_data       registered register-file write port
//   pending                       bit i set while a queued or issuing write targets addr[2:0]==i
//
// Build option: define REGFILE_ARB_RR_EN for round-robin arbitration on
// contention; otherwise requester 0 has fixed priority and requester 1 may
// starve under continuous requester-0 traffic.
// DATA_W/ADDR_W must match REG_DATA_W/REG_ADDR_W of regfile_pkg, since the
// FIFOs store the package request struct.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s0_valid,
  input  logic [ADDR_W-1:0] s0_addr,
  input  logic [DATA_W-1:0] s0_data,
  output logic              s0_ready,
  input  logic              s1_valid,
  input  logic [ADDR_W-1:0] s1_addr,
  input  logic [DATA_W-1:0] s1_data,
  output logic              s1_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_data,
  output logic [NUM_REGS-1:0] pending
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  wb_req_t                         req0, req1;
  wb_req_t                         head0, head1;
  logic [CNT_W-1:0]                cnt0, cnt1;
  logic [DEPTH-1:0]                vld0, vld1;
  logic [DEPTH-1:0][REG_SEL_W-1:0] sel0, sel1;
  logic                            push0, push1;
  logic                            ne0, ne1;
  logic                            gnt0, gnt1;

  // Ready comes from the fill count only, so there is no valid->ready path.
  assign s0_ready = (cnt0 != CNT_W'(DEPTH));
  assign s1_ready = (cnt1 != CNT_W'(DEPTH));
  assign push0    = s0_valid & s0_ready;
  assign push1    = s1_valid & s1_ready;
  assign req0     = '{addr: s0_addr, data: s0_data};
  assign req1     = '{addr: s1_addr, data: s1_data};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo0 (
    .clk      (clk),
    .rst      (rst),
    .push     (push0),
    .push_req (req0),
    .pop      (gnt0),
    .head     (head0),
    .count    (cnt0),
    .ent_vld  (vld0),
    .ent_sel  (sel0)
  );

  wb_fifo #(.DEPTH(DEPTH)) u_fifo1 (
    .clk      (clk),
    .rst      (rst),
    .push     (push1),
    .push_req (req1),
    .pop      (gnt1),
    .head     (head1),
    .count    (cnt1),
    .ent_vld  (vld1),
    .ent_sel  (sel1)
  );

  assign ne0 = (cnt0 != '0);
  assign ne1 = (cnt1 != '0);

`ifdef REGFILE_ARB_RR_EN
  // 1 when requester 1 took the most recent grant. Resetting it to 1 hands
  // the first contention to requester 0.
  logic last_gnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              last_gnt <= 1'b1;
    else if (gnt0 | gnt1) last_gnt <= gnt1;
  end

  assign gnt1 = ne1 & (~ne0 | ~last_gnt);
`else
  assign gnt1 = ne1 & ~ne0;
`endif
  assign gnt0 = ne0 & ~gnt1;

  // Issue register: the granted head is popped and captured on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we   <= 1'b0;
      rf_addr <= '0;
      rf_data <= '0;
    end else begin
      rf_we <= gnt0 | gnt1;
      if (gnt0) begin
        rf_addr <= head0.addr;
        rf_data <= head0.data;
      end else if (gnt1) begin
        rf_addr <= head1.addr;
        rf_data <= head1.data;
      end
    end
  end

  // Every live FIFO entry plus the write currently on the port.
  always_comb begin
    pending = rf_we ? reg_onehot(rf_addr[REG_SEL_W-1:0]) : '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld0[i]) pending = pending | reg_onehot(sel0[i]);
      if (vld1[i]) pending = pending | reg_onehot(sel1[i]);
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       s0_valid, s1_valid;
  logic [4:0] s0_addr, s1_addr;
  logic [7:0] s0_data, s1_data;
  logic       s0_ready, s1_ready;
  logic       rf_we;
  logic [4:0] rf_addr;
  logic [7:0] rf_data;
  logic [7:0] pending;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.DATA_W(8), .ADDR_W(5), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .s0_valid (s0_valid),
    .s0_addr  (s0_addr),
    .s0_data  (s0_data),
    .s0_ready (s0_ready),
    .s1_valid (s1_valid),
    .s1_addr  (s1_addr),
    .s1_data  (s1_data),
    .s1_ready (s1_ready),
    .rf_we    (rf_we),
    .rf_addr  (rf_addr),
    .rf_data  (rf_data),
    .pending  (pending)
  );

  typedef struct { logic [4:0] addr; logic [7:0] data; } wr_t;
  typedef struct { logic [4:0] addr; logic [7:0] data; int gap; } item_t;

  // Reference model state: contents of each requester queue, expected writes.
  wr_t        q0[$], q1[$], exp_q[$];
  bit         iss_vld;
  logic [4:0] iss_addr;
  bit         last1;

  item_t      stim0[$], stim1[$];
  logic [7:0] got_log[$], exp_log[$];
  logic [7:0] rf_dut [32];
  int         errors = 0;
  int         checks = 0;
  bit         abort  = 0;
  int         s1_stall = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_log(input string name);
    chk({name, "_count"}, got_log.size(), exp_log.size());
    for (int i = 0; i < exp_log.size() && i < got_log.size(); i++)
      chk(name, got_log[i], exp_log[i]);
  endtask

  task automatic add(input int p, input logic [4:0] a, input logic [7:0] d, input int g);
    item_t it;
    it.addr = a; it.data = d; it.gap = g;
    if (p == 0) stim0.push_back(it); else stim1.push_back(it);
  endtask

  task automatic set_req(input int p, input logic v, input logic [4:0] a, input logic [7:0] d);
    if (p == 0) begin s0_valid = v; s0_addr = a; s0_data = d; end
    else        begin s1_valid = v; s1_addr = a; s1_data = d; end
  endtask

  // Requester driver: called at posedge+1, holds valid and payload until accepted.
  task automatic drive(input int p);
    item_t it;
    bit    acc;
    int    guard;
    while (1) begin
      if (abort) break;
      if (p == 0 ? stim0.size() == 0 : stim1.size() == 0) break;
      it = (p == 0) ? stim0.pop_front() : stim1.pop_front();
      for (int g = 0; g < it.gap && !abort; g++) begin
        @(posedge clk); #1;
      end
      if (abort) break;
      set_req(p, 1'b1, it.addr, it.data);
      acc = 0;
      guard = 0;
      while (!acc && !abort) begin
        @(negedge clk);
        acc = (p == 0) ? s0_ready : s1_ready;
        @(posedge clk); #1;
        guard++;
        if (!acc && guard > 400) begin
          checks++; errors++;
          $display("FAIL accept_timeout: requester %0d never became ready, required acceptance within 400 cycles", p);
          abort = 1;
        end
      end
      set_req(p, 1'b0, it.addr, it.data);
    end
    set_req(p, 1'b0, 5'd0, 8'd0);
  endtask

  task automatic run_phase();
    fork
      drive(0);
      drive(1);
    join
    repeat (2 * DEPTH + 6) @(posedge clk);
    #1;
  endtask

  // Reference model: at each edge the oldest waiting request of the winning
  // requester moves onto the write port, then newly accepted requests join
  // their queue (acceptance judged on the pre-edge queue length).
  initial begin
    last1   = 1;
    iss_vld = 0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        q0.delete(); q1.delete(); exp_q.delete();
        iss_vld = 0;
        last1   = 1;
      end else begin : model_step
        bit  r0, r1, take1;
        wr_t e, n;
        r0 = (q0.size() < DEPTH);
        r1 = (q1.size() < DEPTH);
        if (q0.size() > 0 && q1.size() > 0) begin
`ifdef REGFILE_ARB_RR_EN
          take1 = !last1;
`else
          take1 = 0;
`endif
        end else begin
          take1 = (q1.size() > 0);
        end
        if (q0.size() > 0 || q1.size() > 0) begin
          e = take1 ? q1.pop_front() : q0.pop_front();
          exp_q.push_back(e);
          iss_vld  = 1;
          iss_addr = e.addr;
          last1    = take1;
        end else begin
          iss_vld = 0;
        end
        if (s0_valid && r0) begin n.addr = s0_addr; n.data = s0_data; q0.push_back(n); end
        if (s1_valid && r1) begin n.addr = s1_addr; n.data = s1_data; q1.push_back(n); end
      end
    end
  end

  // Monitor: compares the DUT against the model away from the clock edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin : mon
        logic [7:0] pm;
        wr_t        e;
        chk("s0_ready", s0_ready, q0.size() != DEPTH);
        chk("s1_ready", s1_ready, q1.size() != DEPTH);
        pm = 8'h00;
        foreach (q0[i]) pm = pm | (8'h01 << q0[i].addr[2:0]);
        foreach (q1[i]) pm = pm | (8'h01 << q1[i].addr[2:0]);
        if (iss_vld) pm = pm | (8'h01 << iss_addr[2:0]);
        chk("pending", pending, pm);
        if (rf_we) begin
          got_log.push_back(rf_data);
          rf_dut[rf_addr] = rf_data;
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_write: got addr=%0d data=%02h, expected no write", rf_addr, rf_data);
          end else begin
            e = exp_q.pop_front();
            chk("rf_addr", rf_addr, e.addr);
            chk("rf_data", rf_data, e.data);
          end
        end else if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          checks++; errors++;
          $display("FAIL missing_write: got rf_we=0, expected addr=%0d data=%02h", e.addr, e.data);
        end
        if (s1_valid && !s1_ready) s1_stall++;
      end
    end
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    set_req(0, 1'b0, 5'd0, 8'd0);
    set_req(1, 1'b0, 5'd0, 8'd0);
    #2;
    chk("reset_rf_we", rf_we, 0);
    chk("reset_rf_addr", rf_addr, 0);
    chk("reset_rf_data", rf_data, 0);
    chk("reset_pending", pending, 0);
    chk("reset_s0_ready", s0_ready, 1);
    chk("reset_s1_ready", s1_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset in the middle of traffic.
    for (int i = 0; i < 8; i++) begin
      add(0, 5'(i), 8'(8'h50 + i), 0);
      add(1, 5'(i + 8), 8'(8'h60 + i), 0);
    end
    @(posedge clk); #1;
    fork
      drive(0);
      drive(1);
      begin
        repeat (3) @(posedge clk);
        #3;
        rst   = 1'b1;
        abort = 1;
        #1;
        chk("midrst_rf_we", rf_we, 0);
        chk("midrst_pending", pending, 0);
        chk("midrst_s0_ready", s0_ready, 1);
        chk("midrst_s1_ready", s1_ready, 1);
      end
    join
    stim0.delete(); stim1.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    abort = 0;
    repeat (5) @(posedge clk);
    #1;

    // Same address from both requesters on the same edge.
    got_log.delete(); exp_log.delete();
    add(0, 5'd5, 8'h01, 0);
    add(1, 5'd5, 8'h02, 0);
    run_phase();
    exp_log.push_back(8'h01); exp_log.push_back(8'h02);
    check_log("same_addr_order");
    chk("same_addr_final", rf_dut[5], 8'h02);

    // Continuous contention.
    got_log.delete(); exp_log.delete();
    for (int i = 0; i < 6; i++) begin
      add(0, 5'd1, 8'(8'h10 + i), 0);
      add(1, 5'd2, 8'(8'h20 + i), 0);
    end
    run_phase();
`ifdef REGFILE_ARB_RR_EN
    for (int i = 0; i < 6; i++) begin
      exp_log.push_back(8'(8'h10 + i));
      exp_log.push_back(8'(8'h20 + i));
    end
`else
    for (int i = 0; i < 6; i++) exp_log.push_back(8'(8'h10 + i));
    for (int i = 0; i < 6; i++) exp_log.push_back(8'(8'h20 + i));
`endif
    check_log("contention_order");

    // Single write.
    got_log.delete(); exp_log.delete();
    add(0, 5'd3, 8'hA5, 0);
    run_phase();
    exp_log.push_back(8'hA5);
    check_log("single_write");
    chk("single_write_rf", rf_dut[3], 8'hA5);

    // Backpressure on requester 1 while requester 0 saturates.
    got_log.delete(); exp_log.delete();
    s1_stall = 0;
    for (int i = 0; i < 6; i++) add(0, 5'd4, 8'(8'h30 + i), 0);
    for (int i = 0; i < 3; i++) add(1, 5'd6, 8'(8'h40 + i), 0);
    run_phase();
`ifndef REGFILE_ARB_RR_EN
    chk("bp_s1_held", s1_stall > 0, 1);
    for (int i = 0; i < 6; i++) exp_log.push_back(8'(8'h30 + i));
    for (int i = 0; i < 3; i++) exp_log.push_back(8'(8'h40 + i));
    check_log("bp_order");
`endif

    // Randomized traffic with idle gaps.
    for (int i = 0; i < 120; i++) begin
      add(0, 5'($urandom_range(0, 31)), 8'($urandom), $urandom_range(0, 2));
      add(1, 5'($urandom_range(0, 31)), 8'($urandom), $urandom_range(0, 2));
    end
    run_phase();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
